// File: rtl/shiftregister_universal.sv
// Universal N-bit shift register: parallel load, single-step shifts, and a start/busy/done shift-by-k engine.
// Optional macro SHREG_ROTATE_EN enables rotate mode (01); without it mode 01 behaves as logical.
module shiftregister_universal #(
   parameter int N  = 10,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          sclr,
   input  logic          load,
   input  logic [N-1:0]  data_in,
   input  logic          shift_s,
   input  logic          start,
   input  logic [CW-1:0] amount,
   input  logic          dir,
   input  logic [1:0]    mode,
   input  logic          ser_in,
   output logic [N-1:0]  data_out,
   output logic          ser_out,
   output logic          busy,
   output logic          done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_reg, state_next;
   logic [N-1:0]  data_reg, data_next;
   logic [CW-1:0] count_reg, count_next;
   logic          dir_reg, dir_next;
   logic [1:0]    mode_reg, mode_next;
   logic          done_reg, done_next;

   // Fill bit depends on mode; mode 11 (and 01 without rotate) falls through to logical.
   function automatic logic [N-1:0] shift_fn(input logic [N-1:0] d, input logic dr,
                                             input logic [1:0] md, input logic si);
      logic fill;
      fill = si;
      if (md == 2'b10) begin
         fill = dr ? d[N-1] : 1'b0;
      end
`ifdef SHREG_ROTATE_EN
      else if (md == 2'b01) begin
         fill = dr ? d[0] : d[N-1];
      end
`endif
      if (dr) return {fill, d[N-1:1]};
      else    return {d[N-2:0], fill};
   endfunction

   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      count_next = count_reg;
      dir_next   = dir_reg;
      mode_next  = mode_reg;
      done_next  = 1'b0;
      if (sclr) begin
         state_next = IDLE;
         data_next  = '0;
         count_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (load) begin
                  data_next = data_in;
               end else if (start) begin
                  dir_next  = dir;
                  mode_next = mode;
                  if (amount == '0) begin
                     done_next = 1'b1;
                  end else begin
                     count_next = amount;
                     state_next = RUN;
                  end
               end else if (shift_s) begin
                  data_next = shift_fn(data_reg, dir, mode, ser_in);
               end
            end
            RUN: begin
               // Latched direction/mode, live serial input; load/start/shift_s are ignored here.
               data_next  = shift_fn(data_reg, dir_reg, mode_reg, ser_in);
               count_next = count_reg - CW'(1);
               if (count_reg == CW'(1)) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         count_reg <= '0;
         dir_reg   <= 1'b0;
         mode_reg  <= 2'b00;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         count_reg <= count_next;
         dir_reg   <= dir_next;
         mode_reg  <= mode_next;
         done_reg  <= done_next;
      end
   end

   assign data_out = data_reg;
   assign busy     = (state_reg == RUN);
   assign done     = done_reg;
   assign ser_out  = ((state_reg == RUN) ? dir_reg : dir) ? data_reg[0] : data_reg[N-1];

endmodule

// File: tb/tb_shiftregister_universal.sv
// Randomised and directed bench for shiftregister_universal against a behavioural model.
// Rotate expectations follow SHREG_ROTATE_EN when it is defined for the build.
module tb_shiftregister_universal;
   localparam int N  = 10;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          clr_n = 1'b0;
   logic          sclr = 1'b0, load = 1'b0, shift_s = 1'b0, start = 1'b0;
   logic [N-1:0]  data_in = '0;
   logic [CW-1:0] amount = '0;
   logic          dir = 1'b0, ser_in = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [N-1:0]  data_out;
   logic          ser_out, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: register value, remaining shifts of the current run, latched controls.
   int m_data = 0;
   int m_left = 0;
   int m_dir  = 0;
   int m_mode = 0;
   int m_done = 0;

   shiftregister_universal #(.N(N), .CW(CW)) dut (
      .clk(clk), .clr_n(clr_n), .sclr(sclr), .load(load), .data_in(data_in),
      .shift_s(shift_s), .start(start), .amount(amount), .dir(dir), .mode(mode),
      .ser_in(ser_in), .data_out(data_out), .ser_out(ser_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic int msb_of(input int d);
      return (d / (1 << (N-1))) % 2;
   endfunction

   function automatic int mshift(input int d, input int dr, input int md, input int si);
      int fill;
      fill = si;
      if (md == 2) fill = dr ? msb_of(d) : 0;
`ifdef SHREG_ROTATE_EN
      if (md == 1) fill = dr ? (d % 2) : msb_of(d);
`endif
      if (dr != 0) return d / 2 + fill * (1 << (N-1));
      return (d * 2 + fill) % (1 << N);
   endfunction

   function automatic int exp_ser();
      int eff;
      eff = (m_left > 0) ? m_dir : int'(dir);
      return eff ? (m_data % 2) : msb_of(m_data);
   endfunction

   // Advance the model with the inputs presented at the coming edge, then wait past that edge.
   task automatic step();
      int nd, nl, ndone, ndir, nmode;
      nd = m_data; nl = m_left; ndone = 0; ndir = m_dir; nmode = m_mode;
      if (sclr) begin
         nd = 0; nl = 0;
      end else if (m_left > 0) begin
         nd = mshift(m_data, m_dir, m_mode, int'(ser_in));
         nl = m_left - 1;
         ndone = (nl == 0);
      end else if (load) begin
         nd = int'(data_in);
      end else if (start) begin
         ndir = int'(dir); nmode = (mode == 2'b11) ? 0 : int'(mode);
         if (amount == 0) ndone = 1; else nl = int'(amount);
      end else if (shift_s) begin
         nd = mshift(m_data, int'(dir), (mode == 2'b11) ? 0 : int'(mode), int'(ser_in));
      end
      @(posedge clk);
      #1;
      m_data = nd; m_left = nl; m_done = ndone; m_dir = ndir; m_mode = nmode;
   endtask

   task automatic do_load(input int v);
      load = 1'b1; data_in = N'(v);
      step();
      load = 1'b0;
   endtask

   // Issue a start, then keep clocking; counts busy and done cycles. Optional input toggling during the run.
   task automatic run(input int k, input logic d, input logic [1:0] md, input logic si,
                      input int nsteps, input bit toggle, output int bc, output int dc);
      bc = 0; dc = 0;
      start = 1'b1; amount = CW'(k); dir = d; mode = md; ser_in = si;
      step();
      start = 1'b0;
      bc += int'(busy); dc += int'(done);
      for (int i = 1; i < nsteps; i++) begin
         if (toggle) begin
            dir = ~dir; load = $urandom_range(0, 1); shift_s = $urandom_range(0, 1);
            data_in = N'($urandom); start = $urandom_range(0, 1);
         end
         step();
         bc += int'(busy); dc += int'(done);
      end
      load = 1'b0; shift_s = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      #3;
      n_checks++;
      if (data_out !== '0 || busy !== 1'b0 || done !== 1'b0)
         begin n_fail++; $display("FAIL reset: data=%h busy=%b done=%b want 000/0/0", data_out, busy, done); end
      @(negedge clk); clr_n = 1'b1;
      step();
      n_checks++;
      if (data_out !== '0 || busy !== 1'b0)
         begin n_fail++; $display("FAIL reset_release: data=%h busy=%b want 000/0", data_out, busy); end
      $display("reset: data=%h busy=%b done=%b", data_out, busy, done);
   endtask

   task automatic test_left_logical();
      int bc, dc;
      do_load('h2B5);
      run(3, 1'b0, 2'b00, 1'b0, 5, 1'b0, bc, dc);
      n_checks++;
      if (data_out !== 10'h1A8 || bc != 3 || dc != 1)
         begin n_fail++; $display("FAIL left_logical: data=%h busy_cyc=%0d done_cyc=%0d want 1a8/3/1", data_out, bc, dc); end
      $display("left_logical: data=%h busy_cyc=%0d done_cyc=%0d", data_out, bc, dc);
   endtask

   task automatic test_rotate();
      int bc, dc;
      do_load('h2B5);
      run(4, 1'b1, 2'b01, 1'b0, 6, 1'b0, bc, dc);
      n_checks++;
`ifdef SHREG_ROTATE_EN
      if (data_out !== 10'h16B)
         begin n_fail++; $display("FAIL rotate: data=%h want 16b", data_out); end
`else
      if (data_out !== 10'h02B)
         begin n_fail++; $display("FAIL rotate_as_logical: data=%h want 02b", data_out); end
`endif
      n_checks++;
      if (bc != 4 || dc != 1)
         begin n_fail++; $display("FAIL rotate_handshake: busy_cyc=%0d done_cyc=%0d want 4/1", bc, dc); end
      $display("rotate: data=%h busy_cyc=%0d done_cyc=%0d", data_out, bc, dc);
   endtask

   task automatic test_arith_ignored();
      int bc, dc;
      do_load('h2B5);
      run(2, 1'b1, 2'b10, 1'b0, 3, 1'b1, bc, dc);
      n_checks++;
      if (data_out !== 10'h3AD || bc != 2 || dc != 1)
         begin n_fail++; $display("FAIL arith_right: data=%h busy_cyc=%0d done_cyc=%0d want 3ad/2/1", data_out, bc, dc); end
      $display("arith_right: data=%h busy_cyc=%0d done_cyc=%0d", data_out, bc, dc);
   endtask

   task automatic test_back_to_back();
      int bc, dc;
      do_load('h2B5);
      run(0, 1'b0, 2'b00, 1'b1, 1, 1'b0, bc, dc);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || data_out !== 10'h2B5)
         begin n_fail++; $display("FAIL zero_amount: done=%b busy=%b data=%h want 1/0/2b5", done, busy, data_out); end
      run(1, 1'b0, 2'b00, 1'b1, 4, 1'b0, bc, dc);
      n_checks++;
      if (data_out !== 10'h16B || bc != 1 || dc != 1)
         begin n_fail++; $display("FAIL back_to_back: data=%h busy_cyc=%0d done_cyc=%0d want 16b/1/1", data_out, bc, dc); end
      $display("back_to_back: data=%h busy_cyc=%0d done_cyc=%0d", data_out, bc, dc);
   endtask

   task automatic test_sclr_abort();
      int bc, dc, dsum;
      do_load('h2B5);
      run(6, 1'b0, 2'b00, 1'b1, 3, 1'b0, bc, dc);
      sclr = 1'b1;
      step();
      sclr = 1'b0;
      dsum = int'(done);
      n_checks++;
      if (data_out !== '0 || busy !== 1'b0)
         begin n_fail++; $display("FAIL sclr_abort: data=%h busy=%b want 000/0", data_out, busy); end
      for (int i = 0; i < 6; i++) begin step(); dsum += int'(done); end
      n_checks++;
      if (dsum != 0)
         begin n_fail++; $display("FAIL sclr_no_done: done_cyc=%0d want 0", dsum); end
      shift_s = 1'b1; ser_in = 1'b1; dir = 1'b0; mode = 2'b00;
      step();
      shift_s = 1'b0;
      n_checks++;
      if (data_out !== 10'h001 || ser_out !== 1'b0)
         begin n_fail++; $display("FAIL sclr_then_shift: data=%h ser_out=%b want 001/0", data_out, ser_out); end
      $display("sclr_abort: data=%h ser_out=%b", data_out, ser_out);
   endtask

   task automatic test_reset_midrun();
      int bc, dc;
      do_load('h2B5);
      run(5, 1'b0, 2'b00, 1'b0, 3, 1'b0, bc, dc);
      #2 clr_n = 1'b0;
      #1;
      n_checks++;
      if (data_out !== '0 || busy !== 1'b0 || done !== 1'b0)
         begin n_fail++; $display("FAIL reset_midrun: data=%h busy=%b done=%b want 000/0/0", data_out, busy, done); end
      m_data = 0; m_left = 0; m_done = 0; m_dir = 0; m_mode = 0;
      $display("reset_midrun: data=%h busy=%b done=%b", data_out, busy, done);
      @(negedge clk); clr_n = 1'b1;
      step();
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         sclr    = ($urandom_range(0, 31) == 0);
         load    = ($urandom_range(0, 7) == 0);
         start   = ($urandom_range(0, 5) == 0);
         shift_s = $urandom_range(0, 1);
         data_in = N'($urandom);
         amount  = CW'($urandom);
         dir     = $urandom_range(0, 1);
         mode    = 2'($urandom);
         ser_in  = $urandom_range(0, 1);
         step();
         n_checks++;
         if (int'(data_out) != m_data || int'(busy) != int'(m_left > 0) ||
             int'(done) != m_done || int'(ser_out) != exp_ser()) begin
            n_fail++; errs++;
            $display("FAIL random[%0d]: data=%h busy=%b done=%b ser=%b want %h/%0d/%0d/%0d",
                     i, data_out, busy, done, ser_out, m_data[N-1:0], int'(m_left > 0), m_done, exp_ser());
         end
      end
      sclr = 1'b0; load = 1'b0; start = 1'b0; shift_s = 1'b0;
      $display("random: 400 cycles, %0d mismatching", errs);
   endtask

   initial begin
      test_reset();
      test_left_logical();
      test_rotate();
      test_arith_ignored();
      test_back_to_back();
      test_sclr_abort();
      test_reset_midrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
